// File: rtl/pix_pattern_gen.sv
// rtl/pix_pattern_gen.sv - registered RGB332 test-pattern source for the VGA pipeline
//
// Purpose:
//   Maps the horizontal/vertical counters of the display controller onto a
//   registered RGB332 pixel. The available patterns are solid colour, eight
//   colour bars, a 32x32 checkerboard and a bouncing box. The pattern select
//   and the box position only change at frame start, which is hc=0, vc=0.
//   The output lags the counters by one clock.
//
// Ports:
//   PIX_CLK     in  1   pixel clock
//   RST         in  1   asynchronous active-high reset
//   hc_i        in  10  horizontal counter
//   vc_i        in  10  vertical counter
//   MODE        in  2   pattern select (0 solid, 1 bars, 2 checker, 3 box)
//   PIX_DATA    out 8   {R[2:0],G[2:0],B[1:0]}, registered
//   FRAME_START out 1   one-cycle pulse aligned with PIX_DATA of pixel (0,0)
//
// Configuration macro:
//   PIX_GEN_BOX_EN  compiles in the bouncing box (mode 3) and its state.
//                   When it is undefined, mode 3 renders SOLID_COLOR.

module pix_pattern_gen #(
  parameter int         H_ACTIVE    = 640,
  parameter int         V_ACTIVE    = 480,
  parameter logic [7:0] SOLID_COLOR = 8'd69,
  parameter int         BOX_SIZE    = 32,
  parameter int         STEP        = 2
) (
  input  logic       PIX_CLK,
  input  logic       RST,
  input  logic [9:0] hc_i,
  input  logic [9:0] vc_i,
  input  logic [1:0] MODE,
  output logic [7:0] PIX_DATA,
  output logic       FRAME_START
);

  // All position comparisons are done with 11 bits so that bx+BOX_SIZE+STEP
  // cannot wrap.
  localparam logic [10:0] H_A   = 11'(H_ACTIVE);
  localparam logic [10:0] V_A   = 11'(V_ACTIVE);
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [10:0] hc_w;
  logic [10:0] vc_w;
  logic        active;
  logic        frame_start;
  logic [1:0]  mode_q;
  logic [7:0]  bar_color;
  logic [7:0]  box_color;
  logic [7:0]  pix_next;

  assign hc_w        = {1'b0, hc_i};
  assign vc_w        = {1'b0, vc_i};
  assign active      = (hc_w < H_A) && (vc_w < V_A);
  assign frame_start = (hc_i == 10'd0) && (vc_i == 10'd0);

  // The pattern select is held for a whole frame so that a MODE change in
  // mid-frame cannot tear the picture.
  always_ff @(posedge PIX_CLK or posedge RST) begin
    if (RST) begin
      mode_q <= 2'd0;
    end else if (frame_start) begin
      mode_q <= MODE;
    end
  end

`ifdef PIX_GEN_BOX_EN
  localparam logic [10:0] BOX_L  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_L = 11'(STEP);
  localparam logic [9:0]  STEP_S = 10'(STEP);

  logic [9:0]  bx;
  logic [9:0]  by;
  logic        dx;
  logic        dy;
  logic [10:0] bx_w;
  logic [10:0] by_w;
  logic        in_box;

  assign bx_w = {1'b0, bx};
  assign by_w = {1'b0, by};

  // The box reverses direction one step before it would cross an edge, so it
  // never leaves the active region.
  always_ff @(posedge PIX_CLK or posedge RST) begin
    if (RST) begin
      bx <= 10'd0;
      by <= 10'd0;
      dx <= 1'b1;
      dy <= 1'b1;
    end else if (frame_start) begin
      if (dx) begin
        if (bx_w + BOX_L + STEP_L > H_A) begin
          dx <= 1'b0;
          bx <= bx - STEP_S;
        end else begin
          bx <= bx + STEP_S;
        end
      end else if (bx_w < STEP_L) begin
        dx <= 1'b1;
        bx <= bx + STEP_S;
      end else begin
        bx <= bx - STEP_S;
      end

      if (dy) begin
        if (by_w + BOX_L + STEP_L > V_A) begin
          dy <= 1'b0;
          by <= by - STEP_S;
        end else begin
          by <= by + STEP_S;
        end
      end else if (by_w < STEP_L) begin
        dy <= 1'b1;
        by <= by + STEP_S;
      end else begin
        by <= by - STEP_S;
      end
    end
  end

  assign in_box = (hc_w >= bx_w) && (hc_w < bx_w + BOX_L) &&
                  (vc_w >= by_w) && (vc_w < by_w + BOX_L);

  always_comb begin
    box_color = in_box ? 8'hE0 : 8'h00;
  end
`else
  always_comb begin
    box_color = SOLID_COLOR;
  end
`endif

  // The bar boundaries are fixed multiples of H_ACTIVE/8. A chain of
  // comparators against them selects the bar without a divider.
  always_comb begin
    bar_color = 8'h00;
    if (hc_w < BAR_W) begin
      bar_color = 8'hFF;
    end else if (hc_w < 11'd2 * BAR_W) begin
      bar_color = 8'hFC;
    end else if (hc_w < 11'd3 * BAR_W) begin
      bar_color = 8'h1F;
    end else if (hc_w < 11'd4 * BAR_W) begin
      bar_color = 8'h1C;
    end else if (hc_w < 11'd5 * BAR_W) begin
      bar_color = 8'hE3;
    end else if (hc_w < 11'd6 * BAR_W) begin
      bar_color = 8'hE0;
    end else if (hc_w < 11'd7 * BAR_W) begin
      bar_color = 8'h03;
    end else begin
      bar_color = 8'h00;
    end
  end

  // The pixel is rendered from the pre-update mode_q and box state, so pixel
  // (0,0) still belongs to the previous frame's settings.
  always_comb begin
    pix_next = 8'h00;
    if (active) begin
      case (mode_q)
        2'd0:    pix_next = SOLID_COLOR;
        2'd1:    pix_next = bar_color;
        2'd2:    pix_next = (hc_i[5] ^ vc_i[5]) ? 8'hFF : 8'h00;
        default: pix_next = box_color;
      endcase
    end
  end

  always_ff @(posedge PIX_CLK or posedge RST) begin
    if (RST) begin
      PIX_DATA    <= 8'h00;
      FRAME_START <= 1'b0;
    end else begin
      PIX_DATA    <= pix_next;
      FRAME_START <= frame_start;
    end
  end

endmodule

// File: tb/tb_pix_pattern_gen.sv
// tb/tb_pix_pattern_gen.sv - scoreboard bench for pix_pattern_gen against an arithmetic pattern model

module tb_pix_pattern_gen;

  localparam int         H_ACTIVE    = 640;
  localparam int         V_ACTIVE    = 480;
  localparam logic [7:0] SOLID_COLOR = 8'd69;
  localparam int         BOX_SIZE    = 32;
  localparam int         STEP        = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hc  = 10'd0;
  logic [9:0] vc  = 10'd0;
  logic [1:0] mode = 2'd0;
  logic [7:0] pix_data;
  logic       frame_start;

  pix_pattern_gen dut (
    .PIX_CLK    (clk),
    .RST        (rst),
    .hc_i       (hc),
    .vc_i       (vc),
    .MODE       (mode),
    .PIX_DATA   (pix_data),
    .FRAME_START(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       fs;
    int         h;
    int         v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  // Model state: the latched mode and the number of frame starts seen since reset.
  int m_mode   = 0;
  int m_frames = 0;

  logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  // The box position after n frame starts is a triangle wave. It runs from 0
  // up to the largest STEP multiple that keeps the box inside, then back down.
  function automatic int box_pos(int n, int limit);
    int half;
    int p;
    half = (limit - BOX_SIZE) / STEP;
    p    = n % (2 * half);
    return (p <= half) ? p * STEP : (2 * half - p) * STEP;
  endfunction

  function automatic logic [7:0] model_pix(int h, int v, int md, int n);
    int bx;
    int by;
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 8'h00;
    case (md)
      0: return SOLID_COLOR;
      1: return bars[h / (H_ACTIVE / 8)];
      2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 8'hFF : 8'h00;
      default: begin
`ifdef PIX_GEN_BOX_EN
        bx = box_pos(n, H_ACTIVE);
        by = box_pos(n, V_ACTIVE);
        return (h >= bx && h < bx + BOX_SIZE && v >= by && v < by + BOX_SIZE) ? 8'hE0 : 8'h00;
`else
        bx = n;
        by = bx;
        return SOLID_COLOR;
`endif
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Applies one counter pair. The expected response is queued at the capturing edge.
  task automatic step(input int h, input int v);
    exp_t e;
    hc = 10'(h);
    vc = 10'(v);
    @(posedge clk);
    e.pix = model_pix(h, v, m_mode, m_frames);
    e.fs  = (h == 0 && v == 0);
    e.h   = h;
    e.v   = v;
    sb.push_back(e);
    if (h == 0 && v == 0) begin
      m_mode = int'(mode);
      m_frames++;
    end
    #1;
  endtask

  task automatic rand_pix(input int count);
    int h;
    int v;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        h = $urandom_range(0, 1023);
        v = $urandom_range(0, 1023);
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      if (h == 0 && v == 0) h = 1;
      step(h, v);
    end
  endtask

  // Asserts reset away from any clock edge and checks that the outputs clear
  // without a clock. Then the model is restarted and reset is released.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_pix", pix_data, 8'h00);
    chk("reset_fs", {7'd0, frame_start}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    sb.delete();
    m_mode   = 0;
    m_frames = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({pix_data, frame_start} !== {e.pix, e.fs}) begin
        n_errs++;
        $display("FAIL pixel(%0d,%0d): got %h/%b want %h/%b",
                 e.h, e.v, pix_data, frame_start, e.pix, e.fs);
      end
    end
  end

  initial begin
    int bx;
    int by;
    #1;
    do_reset();

    // Mode 0 and blanking, including counter values beyond the frame totals.
    mode = 2'd0;
    step(0, 0);
    step(0, 0);
    step(639, 479);
    step(640, 0);
    step(0, 480);
    step(799, 524);
    step(1023, 1023);
    rand_pix(20);

    // Mode 1: the first frame start still renders with the old mode.
    mode = 2'd1;
    step(0, 0);
    for (int k = 0; k < 8; k++) begin
      step(k * 80, 10);
      step(k * 80 + 79, 10);
    end
    step(640, 10);
    rand_pix(20);

    // Mode 2 with a mid-frame switch back to mode 0.
    mode = 2'd2;
    step(0, 0);
    step(32, 0);
    step(32, 32);
    step(100, 100);
    mode = 2'd0;
    step(200, 100);
    step(63, 300);
    rand_pix(20);
    step(0, 0);
    step(32, 0);
    rand_pix(10);

    // Reset in mid-frame while the counters are running, then a clean restart.
    mode = 2'd2;
    step(100, 200);
    step(101, 200);
    do_reset();
    step(0, 0);
    step(32, 0);
    rand_pix(10);

    // Box bounce on both axes. The box probes are placed from the model's
    // position, and a few random MODE changes occur near the end.
    mode = 2'd3;
    for (int f = 0; f < 660; f++) begin
      if (f >= 640) mode = 2'($urandom_range(0, 3));
      step(0, 0);
      bx = box_pos(m_frames, H_ACTIVE);
      by = box_pos(m_frames, V_ACTIVE);
      step(bx, by);
      step(bx + BOX_SIZE - 1, by + BOX_SIZE - 1);
      step(bx + BOX_SIZE, by);
      step(bx, by + BOX_SIZE);
      if (bx > 0) step(bx - 1, by);
      if (by > 0) step(bx, by - 1);
      if (f >= 640 && $urandom_range(0, 1) == 1) mode = 2'($urandom_range(0, 3));
      rand_pix(3);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
